// File: rtl/sort_pkg.sv
// sort_pkg: shared helpers for the bitonic sorting network.
// Stage count, entry field access and lane wiring for compare-exchange units.
package sort_pkg;

  // Number of compare-exchange stages for 2**log_n lanes.
  function automatic int sort_stages(input int log_n);
    return log_n * (log_n + 1) / 2;
  endfunction

  // Key field of an entry, zero-extended to 64 bits.
  function automatic logic [63:0] key_of(
    input logic [63:0] e,
    input int          dsize,
    input int          offset
  );
    logic [63:0] mask;
    mask = (dsize - offset >= 64) ? '1 :
           ((64'd1 << (dsize - offset)) - 64'd1);
    return (e >> offset) & mask;
  endfunction

  // Symbol field of an entry, zero-extended to 64 bits.
  function automatic logic [63:0] sym_of(
    input logic [63:0] e,
    input int          offset
  );
    logic [63:0] mask;
    mask = (offset >= 64) ? '1 : ((64'd1 << offset) - 64'd1);
    return e & mask;
  endfunction

  // Lane paired with `lane` at step q.
  function automatic int partner(input int lane, input int q);
    return lane ^ (1 << q);
  endfunction

  // Lower lane of compare unit k at step q: insert a 0 at bit q.
  function automatic int lo_lane(input int k, input int q);
    return ((k >> q) << (q + 1)) | (k & ((1 << q) - 1));
  endfunction

  // Ascending network direction (0) unless bit p+1 of the lane is set.
  function automatic logic unit_dir(input int lane, input int p);
    return ((lane >> (p + 1)) & 1) != 0;
  endfunction

endpackage

// File: rtl/bitonic_cmp_swap.sv
// bitonic_cmp_swap: combinational two-entry compare-exchange.
// a/b in (lower/upper lane), dir 0 = min to lo; lo/hi out.
module bitonic_cmp_swap
  import sort_pkg::*;
#(
  parameter int DSIZE     = 18,
  parameter int OFFSET    = 8,
  parameter int TIE_BREAK = 1
) (
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  input  logic             dir,
  output logic [DSIZE-1:0] lo,
  output logic [DSIZE-1:0] hi
);

  logic [63:0] ka;
  logic [63:0] kb;
  logic [63:0] sa;
  logic [63:0] sb;
  logic        a_gt_b;
  logic        b_gt_a;
  logic        swap;

  always_comb begin
    ka = key_of(64'(a), DSIZE, OFFSET);
    kb = key_of(64'(b), DSIZE, OFFSET);
    sa = sym_of(64'(a), OFFSET);
    sb = sym_of(64'(b), OFFSET);
    if (TIE_BREAK != 0) begin
      a_gt_b = (ka > kb) || ((ka == kb) && (sa > sb));
      b_gt_a = (kb > ka) || ((ka == kb) && (sb > sa));
    end else begin
      a_gt_b = ka > kb;
      b_gt_a = kb > ka;
    end
    // Strict compare only: equal entries never move.
    swap = dir ? b_gt_a : a_gt_b;
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end

endmodule

// File: rtl/bitonic_sort_pipe.sv
// bitonic_sort_pipe: pipelined bitonic sorter, one register per stage.
// in_* / out_* valid-ready vector ports, per-vector desc and tag, busy.
module bitonic_sort_pipe
  import sort_pkg::*;
#(
  parameter int DSIZE     = 18,
  parameter int OFFSET    = 8,
  parameter int LOG_N     = 4,
  parameter int TAG_W     = 4,
  parameter int TIE_BREAK = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [(DSIZE<<LOG_N)-1:0] in_data,
  input  logic                      in_desc,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [(DSIZE<<LOG_N)-1:0] out_data,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      busy
);

  localparam int N = 1 << LOG_N;
  localparam int S = sort_stages(LOG_N);
  localparam int W = N * DSIZE;

  logic [S-1:0][W-1:0]     net_in;
  logic [S-1:0][W-1:0]     net_out;
  logic [S-1:0]            net_valid;
  logic [S-1:0]            net_desc;
  logic [S-1:0][TAG_W-1:0] net_tag;

  logic [S-1:0][W-1:0]     st_data;
  logic [S-1:0]            st_valid;
  logic [S-1:0]            st_desc;
  logic [S-1:0][TAG_W-1:0] st_tag;

  logic adv;
  logic desc_unused;

  // Whole pipe moves together; no per-stage bubble collapse.
  assign adv      = !st_valid[S-1] || out_ready;
  assign in_ready = adv;

  for (genvar p = 0; p < LOG_N; p++) begin : g_phase
    for (genvar j = 0; j <= p; j++) begin : g_step
      localparam int SI = p * (p + 1) / 2 + j;
      localparam int Q  = p - j;

      if (SI == 0) begin : g_first
        assign net_in[SI]    = in_data;
        assign net_valid[SI] = in_valid;
        assign net_desc[SI]  = in_desc;
        assign net_tag[SI]   = in_tag;
      end else begin : g_next
        assign net_in[SI]    = st_data[SI-1];
        assign net_valid[SI] = st_valid[SI-1];
        assign net_desc[SI]  = st_desc[SI-1];
        assign net_tag[SI]   = st_tag[SI-1];
      end

      for (genvar k = 0; k < N / 2; k++) begin : g_unit
        localparam int LO = lo_lane(k, Q);
        localparam int HI = partner(LO, Q);

        bitonic_cmp_swap #(
          .DSIZE     (DSIZE),
          .OFFSET    (OFFSET),
          .TIE_BREAK (TIE_BREAK)
        ) u_cs (
          .a   (net_in[SI][LO*DSIZE +: DSIZE]),
          .b   (net_in[SI][HI*DSIZE +: DSIZE]),
          .dir (unit_dir(LO, p) ^ net_desc[SI]),
          .lo  (net_out[SI][LO*DSIZE +: DSIZE]),
          .hi  (net_out[SI][HI*DSIZE +: DSIZE])
        );
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid <= '0;
      st_desc  <= '0;
      st_tag   <= '0;
      st_data  <= '0;
    end else if (adv) begin
      st_valid <= net_valid;
      st_desc  <= net_desc;
      st_tag   <= net_tag;
      st_data  <= net_out;
    end
  end

  // Mode bit of the final stage has no consumer.
  assign desc_unused = st_desc[S-1];

  assign out_valid = st_valid[S-1];
  assign out_data  = st_data[S-1];
  assign out_tag   = st_tag[S-1];
  assign busy      = |st_valid;

endmodule
